// File: rtl/mac_feeder.sv
// Dot-product sequencer: streams A/B operands from two read-latency-1 buffers
// into an external MAC and hands back the accumulated result.
module mac_feeder #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 8,
  parameter int K_MAX  = 16,
  localparam int LEN_W = $clog2(K_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [ADDR_W-1:0]        a_base,
  input  logic [ADDR_W-1:0]        b_base,
  input  logic [LEN_W-1:0]         len,
  output logic                     a_rd_en,
  output logic                     b_rd_en,
  output logic [ADDR_W-1:0]        a_rd_addr,
  output logic [ADDR_W-1:0]        b_rd_addr,
  input  logic signed [DATA_W-1:0] a_rd_data,
  input  logic signed [DATA_W-1:0] b_rd_data,
  output logic                     mac_en,
  output logic                     mac_clear,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic signed [ACC_W-1:0]  mac_acc,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, OUT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_base_q, b_base_q;
  logic [LEN_W-1:0]    len_q, idx_q, len_clamped;
  logic                drain_q;
  logic                mac_en_q;
  logic signed [ACC_W-1:0] res_q;

  assign len_clamped = (len > LEN_W'(K_MAX)) ? LEN_W'(K_MAX) : len;

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    a_rd_en     = 1'b0;
    mac_clear   = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = CLEAR;
      end
      CLEAR: begin
        mac_clear = 1'b1;
        state_d   = (len_q != '0) ? FETCH : DRAIN;
      end
      FETCH: begin
        a_rd_en = 1'b1;
        if (idx_q == len_q - LEN_W'(1)) state_d = DRAIN;
      end
      // first cycle carries the last mac_en, second lets the accumulator settle
      DRAIN: if (drain_q) state_d = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign b_rd_en   = a_rd_en;
  assign a_rd_addr = a_rd_en ? a_base_q + ADDR_W'(idx_q) : '0;
  assign b_rd_addr = b_rd_en ? b_base_q + ADDR_W'(idx_q) : '0;
  assign mac_en    = mac_en_q;
  assign mac_a     = a_rd_data;
  assign mac_b     = b_rd_data;
  assign res_data  = res_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_base_q <= '0;
      b_base_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      mac_en_q <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mac_en_q <= a_rd_en;
      case (state_q)
        IDLE: if (start_valid) begin
          a_base_q <= a_base;
          b_base_q <= b_base;
          len_q    <= len_clamped;
          idx_q    <= '0;
          drain_q  <= 1'b0;
        end
        FETCH: idx_q <= idx_q + LEN_W'(1);
        DRAIN: begin
          drain_q <= ~drain_q;
          if (drain_q) res_q <= mac_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width (signed).
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/result width (signed).
REQ-003 SHALL have parameter ADDR_W, default 8, operand buffer address width.
REQ-004 SHALL have parameter K_MAX, default 16, maximum dot-product length; LEN_W = $clog2(K_MAX+1).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports start_valid in 1 / start_ready out 1  job request handshake.
REQ-008 SHALL have ports a_base, b_base  in  ADDR_W each  start addresses of the A and B vectors.
REQ-009 SHALL have port len  in  LEN_W  number of products in the job.
REQ-010 SHALL have ports a_rd_en, b_rd_en out 1 / a_rd_addr, b_rd_addr out ADDR_W  buffer read requests.
REQ-011 SHALL have ports a_rd_data, b_rd_data  in  DATA_W signed  read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have ports mac_en, mac_clear out 1 / mac_a, mac_b out DATA_W signed / mac_acc in ACC_W signed  MAC control, operands and accumulator.
REQ-013 SHALL have ports res_valid out 1 / res_ready in 1 / res_data out ACC_W signed  result handshake.
REQ-014 SHALL have port busy  out 1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, FETCH, DRAIN, OUT.
REQ-016 IDLE: start_ready=1; on start_valid&&start_ready, SHALL latch a_base, b_base and min(len, K_MAX), then go to CLEAR.
REQ-017 start_ready SHALL be 0 in every state except IDLE.
REQ-018 CLEAR: mac_clear=1 for exactly one cycle, no reads issued; next state FETCH if latched len>0, else DRAIN.
REQ-019 FETCH: one read per cycle on both ports, index i=0..len-1, a_rd_addr=a_base+i, b_rd_addr=b_base+i, modulo 2^ADDR_W; after index len-1, go to DRAIN.
REQ-020 mac_en SHALL equal the previous cycle's a_rd_en (1-cycle delayed); mac_a=a_rd_data, mac_b=b_rd_data, combinationally.
REQ-021 mac_clear and mac_en SHALL never be high in the same cycle.
REQ-022 DRAIN: exactly 2 cycles (last mac_en, then accumulator settle); at end of the second cycle, SHALL capture mac_acc into res_data and go to OUT.
REQ-023 OUT: res_valid=1 and res_data stable until res_ready sampled high; then return to IDLE.
REQ-024 No new start SHALL be accepted in the cycle of the result handshake; start_ready rises the following cycle.
REQ-025 Latency: start handshake at cycle 0 -> res_valid first high at cycle len+4 (len=0 -> cycle 4, result 0).
REQ-026 Result arithmetic SHALL be the signed sum of products wrapping modulo 2^ACC_W; no saturation.
REQ-027 len>K_MAX SHALL be clamped to K_MAX.

Reset
REQ-028 When rst=1 at a clock edge, SHALL go to IDLE and drive start_ready=1, busy=0, a_rd_en=b_rd_en=0, mac_en=0, mac_clear=0, res_valid=0, res_data=0, addresses=0, in the cycle after that edge.
REQ-029 Reset mid-job SHALL abandon the job: no further reads, mac_en or res_valid; the next job SHALL start with a CLEAR.

Verification
REQ-030 A=[1,2,3,4], B=[5,6,7,8], len=4, res_ready=1 -> res_data=70, res_valid at cycle 8, exactly 4 mac_en pulses.
REQ-031 A=[-128,-128], B=[-128,127], len=2 -> res_data=16384-16256=128; signed operands correct.
REQ-032 len=0 -> one mac_clear pulse, no rd_en, res_data=0 at cycle 4.
REQ-033 a_base=254, len=4 -> a_rd_addr sequence 254,255,0,1.
REQ-034 res_ready held low 10 cycles in OUT -> res_valid and res_data held constant, start_ready=0, no reads; back-to-back second job gets a fresh CLEAR and an independent result.
REQ-035 rst asserted during FETCH at i=2 -> next cycle all outputs at reset values; subsequent len=1 job (3x4) returns 12.
